risc_pipe_mips32: RTL and testbench
===================================

RISC_PIPE_MIPS32 -- requirements
Module: risc_pipe_mips32

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port clk SHALL be an input, 1 bit wide; it is the rising-edge clock for all state.
REQ-003 Port rst_n SHALL be an input, 1 bit wide; it is the synchronous active-low reset.
REQ-004 Port halted SHALL be an output, 1 bit wide; it mirrors the internal HALTED flag.
REQ-005 Internal arrays and registers SHALL be named exactly as follows, because benches preload and check them hierarchically:
- Reg[0:31], 32 bits each.
- Mem[0:1023], 32 bits each.
- PC, 32 bits.
- HALTED, 1 bit.
- TAKEN_BRANCH, 1 bit.

Function
REQ-006 The pipeline SHALL have 5 stages, IF, ID, EX, MEM and WB, separated by IF/ID, ID/EX, EX/MEM and MEM/WB registers, all updated on the rising edge of clk.
REQ-007 Mem SHALL be a unified, word-addressed instruction and data memory.
- Address = low 10 bits of the byte-free word address.
- Reads are combinational.
- Writes are synchronous.
REQ-008 Instruction fields SHALL be:
- op = [31:26]
- rs = [25:21]
- rt = [20:16]
- rd = [15:11]
- imm = [15:0], sign-extended to 32 bits.
REQ-009 Register-register opcodes SHALL write rd from rs op rt:
- ADD = 000000
- SUB = 000001
- AND = 000010
- OR = 000011
- SLT = 000100 (signed, result 1 or 0)
- MUL = 000101 (low 32 bits of the product)
REQ-010 Register-immediate opcodes SHALL write rt from rs op imm:
- ADDI = 001010
- SUBI = 001011
- SLTI = 001100 (signed)
REQ-011 LW (001000) SHALL perform rt <= Mem[rs+imm]; SW (001001) SHALL perform Mem[rs+imm] <= rt in the MEM stage.
REQ-012 BNEQZ (001101) and BEQZ (001110) SHALL compute target = (address of branch + 1) + imm and condition = (rs != 0) or (rs == 0) respectively, both in EX.
REQ-013 HLT (111111) SHALL set HALTED=1 when it reaches WB; from then on, PC, all pipeline registers, Reg and Mem SHALL hold their values until reset.
REQ-014 Any undefined opcode SHALL execute as a no-op: no register write, no memory write, no branch.
REQ-015 Writes to Reg[0] SHALL be ignored; register reads of index 0 SHALL return Reg[0] as stored.
REQ-016 IF SHALL normally fetch Mem[PC] and advance PC to PC+1 each cycle.
REQ-017 When a taken branch is held in EX/MEM:
- IF SHALL fetch from the target and set PC = target+1.
- TAKEN_BRANCH SHALL be 1 for that cycle, and 0 otherwise.
- The two younger instructions in IF/ID and ID/EX SHALL be squashed to no-ops (taken-branch penalty of 2 cycles).
REQ-018 There SHALL be no hazard-detection stall.
- An ID-stage register read SHALL return the newest value written by any older instruction at distance ≥2 instructions.
- This is done by bypassing from the MEM/WB write-back value and the EX/MEM result, including combinational LW data.
- A back-to-back dependency (distance 1) is unsupported; software inserts a dummy instruction.
REQ-019 A branch SHALL observe its rs value under the same distance rule as REQ-018.

Reset
REQ-020 While rst_n=0 at a rising edge, the block SHALL apply the following reset values:
- PC=0, HALTED=0, TAKEN_BRANCH=0.
- All pipeline registers hold no-ops, with no pending write or branch.
REQ-021 Reset SHALL NOT alter Reg or Mem, so preloaded contents survive reset.
REQ-022 Reset applied mid-program SHALL discard all in-flight instructions and restart fetching at address 0 on the first cycle after rst_n returns to 1.

Verification
REQ-023 Add test: preload Reg[k]=k, Mem[0..3] = ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; dummy OR; then ADD R4,R1,R2 and HLT -> R1=10, R2=20, R3=25, R4=30, halted=1.
REQ-024 Load/store test: Mem[120]=85, LW R2,0(R1) with R1=120, dummy, ADDI R2,R2,45, dummy, SW R2,1(R1), HLT -> Mem[121]=130.
REQ-025 Factorial test: program 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000 with Mem[200]=7 -> Mem[198]=5040, R2=5040, R3=0, halted=1.
REQ-026 Branch squash test: BEQZ R0 with target skipping two ADDI R5 instructions -> R5 unchanged and TAKEN_BRANCH pulses for exactly 1 cycle.
REQ-027 Halt/reset test: after HLT, further clocks leave Reg, Mem and PC constant; then rst_n=0 for 1 cycle -> PC=0, halted=0, and the program reruns with identical results.
REQ-028 R0 test: ADDI R0,R0,5 followed by ADD R6,R0,R0 -> Reg[0]=0 and R6=0.

Source files
------------

// File: rtl/risc_pipe_mips32.sv
// Five-stage MIPS32-style pipeline (IF/ID/EX/MEM/WB) with unified word memory,
// forwarding into ID, two-cycle taken-branch squash and a HLT freeze.
module risc_pipe_mips32 (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned AW        = 10;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;
    // Undefined opcode used as the bubble that squashed/reset stages carry.
    localparam logic [5:0] OP_NOP   = 6'b111000;
    localparam logic [XLEN-1:0] NOP_IR = {OP_NOP, 26'd0};

    logic [XLEN-1:0] Reg [0:NREG-1];
    logic [XLEN-1:0] Mem [0:MEM_WORDS-1];
    logic [XLEN-1:0] PC;
    logic            HALTED;
    logic            TAKEN_BRANCH;

    logic [XLEN-1:0] if_id_ir, if_id_npc;
    logic [5:0]      id_ex_op;
    logic [4:0]      id_ex_dst;
    logic            id_ex_wr;
    logic [XLEN-1:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;
    logic [5:0]      ex_mem_op;
    logic [4:0]      ex_mem_dst;
    logic            ex_mem_wr;
    logic [XLEN-1:0] ex_mem_alu, ex_mem_b;
    logic [4:0]      mem_wb_dst;
    logic            mem_wb_wr;
    logic [XLEN-1:0] mem_wb_val;

    logic [5:0]      id_op_c;
    logic [4:0]      id_rs_c, id_rt_c, id_rd_c, id_dst_c;
    logic            id_wr_c;
    logic [XLEN-1:0] id_imm_c, rs_val_c, rt_val_c, ex_mem_val_c;
    logic [XLEN-1:0] alu_c;
    logic            cond_c;

    assign halted = HALTED;

    function automatic logic is_rr(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
    endfunction

    function automatic logic is_ri(input logic [5:0] op);
        return op inside {OP_ADDI, OP_SUBI, OP_SLTI, OP_LW};
    endfunction

    // ID decode plus register read with forwarding; EX/MEM is newest, R0 never forwarded.
    always_comb begin
        id_op_c  = if_id_ir[31:26];
        id_rs_c  = if_id_ir[25:21];
        id_rt_c  = if_id_ir[20:16];
        id_rd_c  = if_id_ir[15:11];
        id_imm_c = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
        id_dst_c = is_rr(id_op_c) ? id_rd_c : id_rt_c;
        id_wr_c  = (is_rr(id_op_c) || is_ri(id_op_c)) && (id_dst_c != 5'd0);

        ex_mem_val_c = (ex_mem_op == OP_LW) ? Mem[ex_mem_alu[AW-1:0]] : ex_mem_alu;

        rs_val_c = Reg[id_rs_c];
        if (mem_wb_wr && mem_wb_dst == id_rs_c) rs_val_c = mem_wb_val;
        if (ex_mem_wr && ex_mem_dst == id_rs_c) rs_val_c = ex_mem_val_c;
        rt_val_c = Reg[id_rt_c];
        if (mem_wb_wr && mem_wb_dst == id_rt_c) rt_val_c = mem_wb_val;
        if (ex_mem_wr && ex_mem_dst == id_rt_c) rt_val_c = ex_mem_val_c;
    end

    // EX: ALU result, effective address or branch target, and branch condition.
    always_comb begin
        alu_c  = '0;
        cond_c = 1'b0;
        case (id_ex_op)
            OP_ADD:                alu_c = id_ex_a + id_ex_b;
            OP_SUB:                alu_c = id_ex_a - id_ex_b;
            OP_AND:                alu_c = id_ex_a & id_ex_b;
            OP_OR:                 alu_c = id_ex_a | id_ex_b;
            OP_SLT:                alu_c = {31'd0, $signed(id_ex_a) < $signed(id_ex_b)};
            OP_MUL:                alu_c = id_ex_a * id_ex_b;
            OP_ADDI, OP_LW, OP_SW: alu_c = id_ex_a + id_ex_imm;
            OP_SUBI:               alu_c = id_ex_a - id_ex_imm;
            OP_SLTI:               alu_c = {31'd0, $signed(id_ex_a) < $signed(id_ex_imm)};
            OP_BNEQZ: begin
                alu_c  = id_ex_npc + id_ex_imm;
                cond_c = (id_ex_a != '0);
            end
            OP_BEQZ: begin
                alu_c  = id_ex_npc + id_ex_imm;
                cond_c = (id_ex_a == '0);
            end
            default: ;
        endcase
    end

    // Pipeline registers and PC; everything freezes once HALTED is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id_ir     <= NOP_IR;
            if_id_npc    <= '0;
            id_ex_op     <= OP_NOP;
            id_ex_dst    <= '0;
            id_ex_wr     <= 1'b0;
            id_ex_a      <= '0;
            id_ex_b      <= '0;
            id_ex_imm    <= '0;
            id_ex_npc    <= '0;
            ex_mem_op    <= OP_NOP;
            ex_mem_dst   <= '0;
            ex_mem_wr    <= 1'b0;
            ex_mem_alu   <= '0;
            ex_mem_b     <= '0;
            mem_wb_dst   <= '0;
            mem_wb_wr    <= 1'b0;
            mem_wb_val   <= '0;
        end else if (!HALTED) begin
            if (TAKEN_BRANCH) begin
                if_id_ir     <= Mem[ex_mem_alu[AW-1:0]];
                if_id_npc    <= ex_mem_alu + 32'd1;
                PC           <= ex_mem_alu + 32'd1;
                id_ex_op     <= OP_NOP;
                id_ex_wr     <= 1'b0;
                ex_mem_op    <= OP_NOP;
                ex_mem_wr    <= 1'b0;
                TAKEN_BRANCH <= 1'b0;
            end else begin
                if_id_ir     <= Mem[PC[AW-1:0]];
                if_id_npc    <= PC + 32'd1;
                PC           <= PC + 32'd1;
                id_ex_op     <= id_op_c;
                id_ex_dst    <= id_dst_c;
                id_ex_wr     <= id_wr_c;
                id_ex_a      <= rs_val_c;
                id_ex_b      <= rt_val_c;
                id_ex_imm    <= id_imm_c;
                id_ex_npc    <= if_id_npc;
                ex_mem_op    <= id_ex_op;
                ex_mem_dst   <= id_ex_dst;
                ex_mem_wr    <= id_ex_wr;
                ex_mem_alu   <= alu_c;
                ex_mem_b     <= id_ex_b;
                TAKEN_BRANCH <= cond_c;
            end
            mem_wb_dst <= ex_mem_dst;
            mem_wb_wr  <= ex_mem_wr;
            mem_wb_val <= ex_mem_val_c;
            if (ex_mem_op == OP_HLT) HALTED <= 1'b1;
        end
    end

    // Architectural state: not reset, so preloaded contents survive.
    always_ff @(posedge clk) begin
        if (rst_n && !HALTED) begin
            if (ex_mem_op == OP_SW) Mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
            if (mem_wb_wr) Reg[mem_wb_dst] <= mem_wb_val;
        end
    end
endmodule

// File: tb/tb_risc_pipe_mips32.sv
// Bench for risc_pipe_mips32: directed programs plus random programs checked
// against a sequential instruction-set interpreter.
module tb_risc_pipe_mips32;
    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4, MUL = 6'd5;
    localparam logic [5:0] LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010, SUBI = 6'b001011;
    localparam logic [5:0] SLTI = 6'b001100, BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111;
    localparam logic [31:0] FILL = 32'hC000_0000;
    localparam logic [31:0] HLT_IR = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    int checks = 0;
    int errors = 0;
    int cyc, tbc;
    logic [31:0] ref_reg [0:31];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] fact_prog [0:10];
    logic [31:0] pc_snap, r2_snap, m_snap;

    risc_pipe_mips32 dut (.clk(clk), .rst_n(rst_n), .halted(halted));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    // Clears memory and sets Reg[k]=k; call only while reset is held.
    task automatic clear_all();
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    endtask

    task automatic run_to_halt(input int budget, output int cycles, output int taken);
        cycles = 0;
        taken = 0;
        rst_n = 1'b1;
        while (!halted && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (dut.TAKEN_BRANCH) taken++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    // Plain sequential interpreter: one instruction per step, branches are immediate.
    task automatic ref_run();
        logic [31:0] pc, ir, a, b, imm, v;
        logic [5:0] op;
        int rs, rt, rd, dst;
        logic wr, done;
        pc = 0;
        done = 1'b0;
        for (int s = 0; s < 2000 && !done; s++) begin
            ir = ref_mem[pc[9:0]];
            op = ir[31:26];
            rs = int'(ir[25:21]);
            rt = int'(ir[20:16]);
            rd = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            a = ref_reg[rs];
            b = ref_reg[rt];
            wr = 1'b1;
            dst = rd;
            v = 0;
            pc = pc + 1;
            case (op)
                ADD:   v = a + b;
                SUB:   v = a - b;
                AND_:  v = a & b;
                OR_:   v = a | b;
                SLT:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                MUL:   v = a * b;
                ADDI:  begin v = a + imm; dst = rt; end
                SUBI:  begin v = a - imm; dst = rt; end
                SLTI:  begin v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; dst = rt; end
                LW:    begin v = ref_mem[(a + imm) % 1024]; dst = rt; end
                SW:    begin ref_mem[(a + imm) % 1024] = b; wr = 1'b0; end
                BNEQZ: begin if (a != 0) pc = pc + imm; wr = 1'b0; end
                BEQZ:  begin if (a == 0) pc = pc + imm; wr = 1'b0; end
                HLT:   begin done = 1'b1; wr = 1'b0; end
                default: wr = 1'b0;
            endcase
            if (wr && dst != 0) ref_reg[dst] = v;
        end
    endtask

    initial begin
        fact_prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
                      32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
                      32'hfc000000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pc", dut.PC, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        // Immediate adds then register add
        clear_all();
        dut.Mem[0] = enc_i(ADDI, 1, 0, 16'd10);
        dut.Mem[1] = enc_i(ADDI, 2, 0, 16'd20);
        dut.Mem[2] = enc_i(ADDI, 3, 0, 16'd25);
        dut.Mem[3] = enc_r(OR_, 7, 7, 7);
        dut.Mem[4] = enc_r(ADD, 4, 1, 2);
        dut.Mem[5] = HLT_IR;
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_pc", dut.PC, 32'd1);
        check("restart_ir", dut.if_id_ir, enc_i(ADDI, 1, 0, 16'd10));
        run_to_halt(200, cyc, tbc);
        check("add_r1", dut.Reg[1], 32'd10);
        check("add_r2", dut.Reg[2], 32'd20);
        check("add_r3", dut.Reg[3], 32'd25);
        check("add_r4", dut.Reg[4], 32'd30);
        check("add_r7", dut.Reg[7], 32'd7);
        check("add_no_branch", 32'(tbc), 32'd0);

        // Load / store with forwarding of load data
        apply_reset();
        clear_all();
        dut.Reg[1] = 32'd120;
        dut.Mem[120] = 32'd85;
        dut.Mem[0] = enc_i(LW, 2, 1, 16'd0);
        dut.Mem[1] = FILL;
        dut.Mem[2] = enc_i(ADDI, 2, 2, 16'd45);
        dut.Mem[3] = FILL;
        dut.Mem[4] = enc_i(SW, 2, 1, 16'd1);
        dut.Mem[5] = HLT_IR;
        run_to_halt(200, cyc, tbc);
        check("ldst_mem121", dut.Mem[121], 32'd130);
        check("ldst_r2", dut.Reg[2], 32'd130);

        // Factorial, interrupted by a mid-program reset first
        apply_reset();
        clear_all();
        for (int i = 0; i < 11; i++) dut.Mem[i] = fact_prog[i];
        dut.Mem[200] = 32'd7;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        apply_reset();
        check("midrst_pc", dut.PC, 32'd0);
        check("midrst_halted", {31'd0, halted}, 32'd0);
        run_to_halt(2000, cyc, tbc);
        check("fact_mem198", dut.Mem[198], 32'd5040);
        check("fact_r2", dut.Reg[2], 32'd5040);
        check("fact_r3", dut.Reg[3], 32'd0);
        check("fact_taken_count", 32'(tbc), 32'd6);

        // Halt freeze, then one-cycle reset and rerun
        pc_snap = dut.PC;
        r2_snap = dut.Reg[2];
        m_snap = dut.Mem[198];
        repeat (20) @(negedge clk);
        check("freeze_pc", dut.PC, pc_snap);
        check("freeze_r2", dut.Reg[2], r2_snap);
        check("freeze_mem", dut.Mem[198], m_snap);
        check("freeze_halted", {31'd0, halted}, 32'd1);
        apply_reset();
        check("rerst_pc", dut.PC, 32'd0);
        check("rerst_halted", {31'd0, halted}, 32'd0);
        dut.Mem[198] = 32'd0;
        run_to_halt(2000, cyc, tbc);
        check("rerun_mem198", dut.Mem[198], 32'd5040);
        check("rerun_r2", dut.Reg[2], 32'd5040);
        check("rerun_r3", dut.Reg[3], 32'd0);

        // Taken branch squashes the two following instructions
        apply_reset();
        clear_all();
        dut.Mem[0] = FILL;
        dut.Mem[1] = enc_i(BEQZ, 0, 0, 16'd2);
        dut.Mem[2] = enc_i(ADDI, 5, 0, 16'd100);
        dut.Mem[3] = enc_i(ADDI, 5, 0, 16'd200);
        dut.Mem[4] = FILL;
        dut.Mem[5] = HLT_IR;
        run_to_halt(200, cyc, tbc);
        check("squash_r5", dut.Reg[5], 32'd5);
        check("squash_pulse", 32'(tbc), 32'd1);

        // R0 is never written
        apply_reset();
        clear_all();
        dut.Mem[0] = enc_i(ADDI, 0, 0, 16'd5);
        dut.Mem[1] = enc_r(ADD, 6, 0, 0);
        dut.Mem[2] = HLT_IR;
        run_to_halt(200, cyc, tbc);
        check("r0_r0", dut.Reg[0], 32'd0);
        check("r0_r6", dut.Reg[6], 32'd0);

        // Random straight-line programs with forward branches, one filler between instructions
        for (int t = 0; t < 6; t++) begin
            logic [31:0] ins;
            int addr, imm;
            apply_reset();
            for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
            ref_reg[0] = 32'd0;
            for (int k = 1; k < 32; k++) ref_reg[k] = $urandom;
            for (int i = 512; i < 576; i++) ref_mem[i] = $urandom;
            addr = 0;
            for (int n = 0; n < 20; n++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: ins = enc_r(6'($urandom_range(0, 5)), $urandom_range(0, 7),
                                            $urandom_range(0, 7), $urandom_range(0, 7));
                    4, 5: ins = enc_i(6'(10 + $urandom_range(0, 2)), $urandom_range(0, 7),
                                      $urandom_range(0, 7), 16'($urandom));
                    6: ins = enc_i(LW, $urandom_range(0, 7), 0, 16'(512 + $urandom_range(0, 63)));
                    7: ins = enc_i(SW, $urandom_range(0, 7), 0, 16'(512 + $urandom_range(0, 63)));
                    8: begin
                        imm = $urandom_range(0, 4);
                        if (addr + 1 + imm > 40) imm = 40 - addr - 1;
                        ins = enc_i(($urandom_range(0, 1) == 0) ? BEQZ : BNEQZ, 0,
                                    $urandom_range(0, 7), 16'(imm));
                    end
                    default: ins = {6'b010000, 26'($urandom)};
                endcase
                ref_mem[addr] = ins;
                ref_mem[addr + 1] = FILL;
                addr += 2;
            end
            ref_mem[40] = HLT_IR;
            for (int i = 0; i < 1024; i++) dut.Mem[i] = ref_mem[i];
            for (int k = 0; k < 32; k++) dut.Reg[k] = ref_reg[k];
            ref_run();
            run_to_halt(1000, cyc, tbc);
            for (int k = 0; k < 8; k++)
                check($sformatf("rand%0d_reg%0d", t, k), dut.Reg[k], ref_reg[k]);
            for (int i = 512; i < 576; i++)
                check($sformatf("rand%0d_mem%0d", t, i), dut.Mem[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
